// File: rtl/frame_pkg.sv
// Shared framing definitions for sample_framer: FSM encoding, separator and frame lengths.
// Defining FRAME_CHECKSUM_EN appends an XOR checksum byte to every frame.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_SEND_START = 2'd2,
        ST_SEND_WAIT  = 2'd3
    } state_t;

    localparam logic [7:0] SEP_BYTE_DEFAULT = 8'h0A;
    localparam int         FRAME_LEN_PLAIN  = 3;
    localparam int         FRAME_LEN_CSUM   = 4;

`ifdef FRAME_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    localparam int FRAME_LEN = CHECKSUM_EN ? FRAME_LEN_CSUM : FRAME_LEN_PLAIN;

    // Byte idx of the frame built around one 16-bit sample, MSB before LSB.
    function automatic logic [7:0] frame_byte(input logic [7:0]  sep,
                                              input logic [15:0] sample,
                                              input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = sep;
            2'd1:    b = sample[15:8];
            2'd2:    b = sample[7:0];
`ifdef FRAME_CHECKSUM_EN
            2'd3:    b = sep ^ sample[15:8] ^ sample[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO with occupancy count; a push while full is refused even if a pop
// happens in the same cycle, and pointers wrap naturally on the power-of-two depth.
module sample_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] count_reg;
    logic [LVL_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_reg == LVL_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign level    = count_reg;
    assign pop_data = mem[rd_ptr_reg];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sample_framer.sv
// Buffers accelerometer samples and sends each as a SEP/MSB/LSB byte frame to a UART.
// Build option: FRAME_CHECKSUM_EN adds a fourth XOR checksum byte per frame.
module sample_framer
    import frame_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SEP_BYTE   = SEP_BYTE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic [15:0]                   sample_data,
    output logic                          sample_ready,
    output logic                          tx_en,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    logic        busy_meta_reg;
    logic        busy_s_reg;
    logic        ready_en_reg;
    logic        overflow_reg;
    state_t      state_reg;
    logic [15:0] frame_reg;
    logic [1:0]  byte_idx_reg;
    logic        tx_en_reg;
    logic [7:0]  tx_data_reg;

    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        push;
    logic        pop;

    // ready_en_reg keeps sample_ready low through reset and for the release edge itself.
    assign sample_ready = ready_en_reg & ~fifo_full;
    assign push         = sample_valid & sample_ready;
    assign pop          = (state_reg == ST_IDLE) & ~fifo_empty;
    assign tx_en        = tx_en_reg;
    assign tx_data      = tx_data_reg;
    assign overflow     = overflow_reg;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sample_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta_reg <= 1'b0;
            busy_s_reg    <= 1'b0;
            ready_en_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            busy_meta_reg <= tx_busy;
            busy_s_reg    <= busy_meta_reg;
            ready_en_reg  <= 1'b1;
            if (sample_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // tx_data only changes while tx_en is low, so the UART always sees a settled byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            frame_reg    <= '0;
            byte_idx_reg <= '0;
            tx_en_reg    <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        frame_reg <= fifo_data;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    byte_idx_reg <= 2'd0;
                    tx_data_reg  <= frame_byte(SEP_BYTE, frame_reg, 2'd0);
                    state_reg    <= ST_SEND_START;
                end
                ST_SEND_START: begin
                    if (!busy_s_reg && !tx_en_reg) begin
                        tx_en_reg <= 1'b1;
                    end else if (busy_s_reg && tx_en_reg) begin
                        tx_en_reg <= 1'b0;
                        state_reg <= ST_SEND_WAIT;
                    end
                end
                ST_SEND_WAIT: begin
                    if (!busy_s_reg) begin
                        if (byte_idx_reg == LAST_IDX) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                            tx_data_reg  <= frame_byte(SEP_BYTE, frame_reg, byte_idx_reg + 2'd1);
                            state_reg    <= ST_SEND_START;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_framer.sv
// Directed scoreboard bench for sample_framer with a behavioural UART busy model.
module tb_sample_framer;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef FRAME_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic             clk;
    logic             rst_n;
    logic             sample_valid;
    logic [15:0]      sample_data;
    logic             sample_ready;
    logic             tx_en;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic             overflow;
    logic [LVL_W-1:0] level;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_q[$];
    int          byte_cnt    = 0;
    int          rise_cnt    = 0;
    bit          async_mode  = 1'b0;

    sample_framer #(
        .FIFO_DEPTH (DEPTH),
        .SEP_BYTE   (8'h0A)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .tx_en        (tx_en),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .overflow     (overflow),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] s);
        logic [7:0] sep;
        sep = 8'h0A;
        exp_q.push_back(sep);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(sep ^ s[15:8] ^ s[7:0]);
`endif
    endtask

    // UART model: accepts a byte when tx_en is seen while idle, then stays busy 10 cycles.
    initial begin
        int d;
        logic [7:0] e;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_en === 1'b1 && !tx_busy) begin
                byte_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $error("FAIL extra_byte: got %02h, none expected", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(e));
                end
                d = async_mode ? int'($urandom_range(9, 1)) : 1;
                #(d);
                tx_busy = 1'b1;
                repeat (10) @(negedge clk);
                d = async_mode ? int'($urandom_range(9, 1)) : 1;
                #(d);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        logic       prev_en;
        logic [7:0] prev_data;
        prev_en   = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1 && prev_en === 1'b1) begin
                check("tx_data_stable", 32'(tx_data), 32'(prev_data));
            end
            if (tx_en === 1'b1 && prev_en !== 1'b1) begin
                rise_cnt++;
            end
            prev_en   = tx_en;
            prev_data = tx_data;
        end
    end

    task automatic send(input logic [15:0] d, input logic exp_ready);
        sample_valid = 1'b1;
        sample_data  = d;
        check("sample_ready", 32'(sample_ready), 32'(exp_ready));
        if (exp_ready) push_frame(d);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_tx_en(input string tag);
        int n;
        n = 0;
        while (tx_en !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_tx_en_timeout"}, 32'(n < 300), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy || tx_en !== 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 4000), 32'd1);
        repeat (6) @(negedge clk);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_pulses"}, 32'(rise_cnt), 32'(byte_cnt));
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(sample_ready), 32'd1);
        rise_cnt = byte_cnt;
    endtask

    initial begin
        int base;
        int n;
        logic [15:0] r;
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = 16'h0000;
        #2;
        apply_reset();

        // Single frame and first-byte latency.
        base = byte_cnt;
        send(16'h12F3, 1'b1);
        n = 1;
        while (tx_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency_ge_3", 32'(n >= 3), 32'd1);
        check("latency_timeout", 32'(n < 100), 32'd1);
        drain("single");
        check("single_bytes", 32'(byte_cnt - base), 32'(FLEN));

        // Burst of five while a frame is in flight: fifth is refused.
        base = byte_cnt;
        send(16'hA001, 1'b1);
        wait_tx_en("burst");
        for (int i = 0; i < 5; i++) begin
            send(16'hB000 + 16'(i), 1'(i < 4));
        end
        check("burst_level_full", 32'(level), 32'(DEPTH));
        check("burst_ready_low", 32'(sample_ready), 32'd0);
        check("burst_overflow", 32'(overflow), 32'd1);
        drain("burst");
        check("burst_bytes", 32'(byte_cnt - base), 32'(5 * FLEN));
        check("overflow_sticky", 32'(overflow), 32'd1);

        apply_reset();

        // Push lands on the same edge as the FSM pop at level 2.
        send(16'hC0DE, 1'b1);
        wait_tx_en("pp");
        send(16'h1111, 1'b1);
        send(16'h2222, 1'b1);
        check("pp_level_2", 32'(level), 32'd2);
        n = 0;
        while (exp_q.size() != 2 * FLEN && n < 1000) begin
            @(negedge clk);
            n++;
        end
        while (tx_busy !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        while (tx_busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("pp_wait_timeout", 32'(n < 1000), 32'd1);
        repeat (2) @(negedge clk);
        check("pp_level_before", 32'(level), 32'd2);
        send(16'h3333, 1'b1);
        check("pp_level_after", 32'(level), 32'd2);
        drain("pp");

        // Reset in the middle of a frame.
        base = byte_cnt;
        send(16'hABCD, 1'b1);
        n = 0;
        while (byte_cnt < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        while (tx_en !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        while (n < 500) begin
            @(posedge clk);
            #2;
            n++;
            if (tx_en === 1'b1) break;
        end
        check("midrst_wait_timeout", 32'(n < 500), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx_en_async", 32'(tx_en), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = byte_cnt;
        repeat (80) @(negedge clk);
        check("midrst_no_bytes", 32'(byte_cnt), 32'(base));
        check("midrst_tx_en_idle", 32'(tx_en), 32'd0);
        rise_cnt = byte_cnt;
        send(16'h5A3C, 1'b1);
        drain("midrst_new");
        check("midrst_new_bytes", 32'(byte_cnt - base), 32'(FLEN));

        // Nine paced samples wrap the FIFO pointers.
        base = byte_cnt;
        for (int i = 1; i <= 9; i++) begin
            send(16'(i), 1'b1);
            repeat (60) @(negedge clk);
        end
        drain("wrap");
        check("wrap_bytes", 32'(byte_cnt - base), 32'(9 * FLEN));
        check("wrap_overflow", 32'(overflow), 32'd0);

        // tx_busy edges at random phase relative to clk.
        async_mode = 1'b1;
        base = byte_cnt;
        for (int i = 0; i < 8; i++) begin
            r = 16'($urandom);
            send(r, 1'b1);
            repeat (int'($urandom_range(80, 60))) @(negedge clk);
        end
        drain("async");
        check("async_bytes", 32'(byte_cnt - base), 32'(8 * FLEN));
        check("async_overflow", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
